// File: rtl/html_tokenizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | html_tokenizer : turns a paced character stream into tag/attr/text/EOF      |
// |                  tokens buffered in a two-entry FIFO.                       |
// | Optional feature macro: HTML_TOKENIZER_ATTR_EN (attribute parsing).         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+

`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif

module html_tokenizer #(
    parameter int NAME_MAX = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    output logic                    char_req,
    input  logic [`CHAR_BITES-1:0]  char,
    input  logic                    src_done,
    output logic                    tok_valid,
    input  logic                    tok_ready,
    output logic [2:0]              tok_type,
    output logic [8*NAME_MAX-1:0]   tok_name,
    output logic [1:0]              tok_attr,
    output logic [7:0]              tok_value,
    output logic                    tok_overflow,
    output logic                    err,
    output logic                    parse_done
);

    localparam int NW = 8 * NAME_MAX;
    localparam int LW = $clog2(NAME_MAX + 1);

    localparam logic [7:0] CH_LT = 8'h3C;
    localparam logic [7:0] CH_GT = 8'h3E;
    localparam logic [7:0] CH_SL = 8'h2F;
    localparam logic [7:0] CH_SP = 8'h20;
`ifdef HTML_TOKENIZER_ATTR_EN
    localparam logic [7:0] CH_EQ = 8'h3D;
`endif

    localparam logic [2:0] TT_OPEN  = 3'd1;
    localparam logic [2:0] TT_CLOSE = 3'd2;
    localparam logic [2:0] TT_TEXT  = 3'd3;
`ifdef HTML_TOKENIZER_ATTR_EN
    localparam logic [2:0] TT_ATTR  = 3'd4;
`endif
    localparam logic [2:0] TT_END   = 3'd5;
    localparam logic [2:0] TT_EOF   = 3'd6;

    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_REQ    = 2'd1,
        F_WAIT   = 2'd2,
        F_SAMPLE = 2'd3
    } fetch_t;

    typedef enum logic [2:0] {
        P_TEXT  = 3'd0,
        P_LT    = 3'd1,
        P_NAME  = 3'd2,
        P_ATTR  = 3'd3,
        P_CNAME = 3'd4
`ifdef HTML_TOKENIZER_ATTR_EN
        ,
        P_ANAME = 3'd5,
        P_AVAL  = 3'd6
`endif
    } parse_t;

    typedef struct packed {
        logic [2:0]    ttype;
        logic [NW-1:0] name;
        logic [1:0]    attr;
        logic [7:0]    value;
        logic          ovf;
    } token_t;

    function automatic token_t mk(input logic [2:0] t, input logic [NW-1:0] n,
                                  input logic [1:0] a, input logic [7:0] v, input logic o);
        mk = '{ttype: t, name: n, attr: a, value: v, ovf: o};
    endfunction

    fetch_t          fstate;
    parse_t          pstate;
    logic [7:0]      c;
    logic            sample;
    logic            step;
    logic            is_letter;
    logic            is_digit;
    logic [NW-1:0]   name;
    logic [NW-1:0]   name_ins;
    logic [LW-1:0]   name_len;
    logic            name_ovf;
    logic            name_clear;
    logic            name_store;
    logic [NW-1:0]   text_name;
    logic [1:0]      count;
    logic [1:0]      count_left;
    logic            pop;
    logic [1:0]      push_n;
    token_t          tok_a;
    token_t          tok_b;
    token_t          q0;
    token_t          q1;

    assign c          = char;
    assign sample     = (fstate == F_SAMPLE);
    assign step       = sample && !src_done;
    assign is_letter  = ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
    assign is_digit   = (c >= 8'h30) && (c <= 8'h39);
    assign text_name  = NW'(c) << (NW - 8);

    assign tok_valid    = (count != 2'd0);
    assign pop          = tok_valid && tok_ready;
    assign count_left   = count - {1'b0, pop};
    assign tok_type     = q0.ttype;
    assign tok_name     = q0.name;
    assign tok_attr     = q0.attr;
    assign tok_value    = q0.value;
    assign tok_overflow = q0.ovf;

`ifdef HTML_TOKENIZER_ATTR_EN
    logic [39:0] abuf;
    logic [2:0]  alen;
    logic [1:0]  attr_id;
    logic [1:0]  attr_match;
    logic [7:0]  value;
    logic [11:0] val_calc;

    assign attr_match = ((alen == 3'd5) && (abuf == "color"))      ? 2'd1 :
                        ((alen == 3'd4) && (abuf[31:0] == "size")) ? 2'd2 : 2'd0;
    assign val_calc   = ({4'd0, value} * 12'd10) + {8'd0, c[3:0]};

    // Only the last five letters are kept; the length check makes the match exact.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            abuf    <= '0;
            alen    <= 3'd0;
            attr_id <= 2'd0;
            value   <= 8'd0;
        end else if (step) begin
            if (pstate == P_ATTR && is_letter) begin
                abuf <= {32'd0, c};
                alen <= 3'd1;
            end else if (pstate == P_ANAME && is_letter) begin
                abuf <= {abuf[31:0], c};
                if (alen != 3'd7) alen <= alen + 3'd1;
            end else if (pstate == P_ANAME && c == CH_EQ) begin
                attr_id <= attr_match;
                value   <= 8'd0;
            end else if (pstate == P_AVAL && is_digit) begin
                value <= (val_calc > 12'd255) ? 8'hFF : val_calc[7:0];
            end
        end
    end
`endif

    // Tag name capture: cleared on every '<', letters appended MSB-first.
    assign name_clear = step && (c == CH_LT);
    assign name_store = step && is_letter &&
                        (pstate == P_LT || pstate == P_NAME || pstate == P_CNAME);

    always_comb begin
        name_ins = name;
        for (int i = 0; i < NAME_MAX; i++) begin
            if (name_len == LW'(i)) name_ins[NW-8-8*i +: 8] = c;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            name     <= '0;
            name_len <= '0;
            name_ovf <= 1'b0;
        end else if (name_clear) begin
            name     <= '0;
            name_len <= '0;
            name_ovf <= 1'b0;
        end else if (name_store) begin
            name <= name_ins;
            if (name_len == LW'(NAME_MAX)) name_ovf <= 1'b1;
            else                           name_len <= name_len + LW'(1);
        end
    end

    always_comb begin
        push_n = 2'd0;
        tok_a  = '0;
        tok_b  = '0;
        if (sample) begin
            if (src_done) begin
                push_n = 2'd1;
                tok_a  = mk(TT_EOF, '0, 2'd0, 8'd0, 1'b0);
            end else if (c != CH_LT) begin
                case (pstate)
                    P_TEXT: begin
                        push_n = 2'd1;
                        tok_a  = mk(TT_TEXT, text_name, 2'd0, 8'd0, 1'b0);
                    end
                    P_NAME: begin
                        if (c == CH_SP) begin
                            push_n = 2'd1;
                            tok_a  = mk(TT_OPEN, name, 2'd0, 8'd0, name_ovf);
                        end else if (c == CH_GT) begin
                            push_n = 2'd2;
                            tok_a  = mk(TT_OPEN, name, 2'd0, 8'd0, name_ovf);
                            tok_b  = mk(TT_END, '0, 2'd0, 8'd0, 1'b0);
                        end
                    end
                    P_ATTR: begin
                        if (c == CH_GT) begin
                            push_n = 2'd1;
                            tok_a  = mk(TT_END, '0, 2'd0, 8'd0, 1'b0);
                        end
                    end
`ifdef HTML_TOKENIZER_ATTR_EN
                    P_ANAME: begin
                        if (c == CH_GT) begin
                            push_n = 2'd1;
                            tok_a  = mk(TT_END, '0, 2'd0, 8'd0, 1'b0);
                        end
                    end
                    P_AVAL: begin
                        if (c == CH_SP) begin
                            push_n = 2'd1;
                            tok_a  = mk(TT_ATTR, '0, attr_id, value, 1'b0);
                        end else if (c == CH_GT) begin
                            push_n = 2'd2;
                            tok_a  = mk(TT_ATTR, '0, attr_id, value, 1'b0);
                            tok_b  = mk(TT_END, '0, 2'd0, 8'd0, 1'b0);
                        end
                    end
`endif
                    P_CNAME: begin
                        if (c == CH_GT && name_len != '0) begin
                            push_n = 2'd1;
                            tok_a  = mk(TT_CLOSE, name, 2'd0, 8'd0, name_ovf);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Two-entry FIFO, q0 is the head; pushes land behind whatever survives the pop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= 2'd0;
            q0    <= '0;
            q1    <= '0;
        end else begin
            if (pop) q0 <= q1;
            if (push_n != 2'd0) begin
                if (count_left == 2'd0) begin
                    q0 <= tok_a;
                    if (push_n == 2'd2) q1 <= tok_b;
                end else begin
                    q1 <= tok_a;
                end
            end
            count <= count_left + push_n;
        end
    end

    // Fetch only with the FIFO drained, so a two-token character always fits.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fstate     <= F_IDLE;
            char_req   <= 1'b0;
            parse_done <= 1'b0;
        end else begin
            char_req <= 1'b0;
            case (fstate)
                F_IDLE: begin
                    if (count_left == 2'd0 && !parse_done) begin
                        fstate   <= F_REQ;
                        char_req <= 1'b1;
                    end
                end
                F_REQ:  fstate <= F_WAIT;
                F_WAIT: fstate <= F_SAMPLE;
                F_SAMPLE: begin
                    fstate <= F_IDLE;
                    if (src_done) parse_done <= 1'b1;
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pstate <= P_TEXT;
            err    <= 1'b0;
        end else if (step) begin
            if (c == CH_LT) begin
                pstate <= P_LT;
                if (pstate != P_TEXT) err <= 1'b1;
            end else begin
                case (pstate)
                    P_TEXT: ;
                    P_LT: begin
                        if (c == CH_SL)     pstate <= P_CNAME;
                        else if (is_letter) pstate <= P_NAME;
                        else begin
                            err    <= 1'b1;
                            pstate <= P_TEXT;
                        end
                    end
                    P_NAME: begin
                        if (c == CH_SP)      pstate <= P_ATTR;
                        else if (c == CH_GT) pstate <= P_TEXT;
                        else if (!is_letter) err    <= 1'b1;
                    end
                    P_ATTR: begin
                        if (c == CH_GT) pstate <= P_TEXT;
`ifdef HTML_TOKENIZER_ATTR_EN
                        else if (is_letter)  pstate <= P_ANAME;
                        else if (c != CH_SP) err    <= 1'b1;
`endif
                    end
`ifdef HTML_TOKENIZER_ATTR_EN
                    P_ANAME: begin
                        if (c == CH_EQ) pstate <= P_AVAL;
                        else if (c == CH_GT) begin
                            err    <= 1'b1;
                            pstate <= P_TEXT;
                        end else if (!is_letter) err <= 1'b1;
                    end
                    P_AVAL: begin
                        if (c == CH_SP)      pstate <= P_ATTR;
                        else if (c == CH_GT) pstate <= P_TEXT;
                        else if (!is_digit)  err    <= 1'b1;
                    end
`endif
                    P_CNAME: begin
                        if (c == CH_GT) begin
                            pstate <= P_TEXT;
                            if (name_len == '0) err <= 1'b1;
                        end else if (!is_letter) err <= 1'b1;
                    end
                    default: pstate <= P_TEXT;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_html_tokenizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_html_tokenizer : reader model + token scoreboard for html_tokenizer.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_html_tokenizer;

    localparam int NAME_MAX = 4;
    localparam logic [2:0] T_OPEN  = 3'd1;
    localparam logic [2:0] T_CLOSE = 3'd2;
    localparam logic [2:0] T_TEXT  = 3'd3;
    localparam logic [2:0] T_ATTR  = 3'd4;
    localparam logic [2:0] T_END   = 3'd5;
    localparam logic [2:0] T_EOF   = 3'd6;
    localparam string MAIN = "<body><p color=7 size=2 >test</p></body>";

    typedef logic [45:0] tok_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        load = 1'b1;
    logic        tok_ready = 1'b0;
    logic        char_req;
    logic [7:0]  ch = 8'h00;
    logic        src_done = 1'b0;
    logic        tok_valid;
    logic [2:0]  tok_type;
    logic [31:0] tok_name;
    logic [1:0]  tok_attr;
    logic [7:0]  tok_value;
    logic        tok_overflow;
    logic        err;
    logic        parse_done;

    string stream = "";
    int    rd_idx = 0;
    int    req_count = 0;
    int    checks = 0;
    int    failures = 0;
    tok_t  sb[$];
    tok_t  mon_obs;
    tok_t  mon_exp;

    always #5 clock = ~clock;

    html_tokenizer #(.NAME_MAX(NAME_MAX)) dut (
        .clock(clock), .resetn(resetn), .char_req(char_req), .char(ch),
        .src_done(src_done), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_type(tok_type), .tok_name(tok_name), .tok_attr(tok_attr),
        .tok_value(tok_value), .tok_overflow(tok_overflow), .err(err),
        .parse_done(parse_done)
    );

    // Character source: answers each request pulse with the next character.
    always @(posedge clock) begin
        if (load) begin
            rd_idx   <= 0;
            src_done <= 1'b0;
            ch       <= 8'h00;
        end else if (char_req) begin
            req_count <= req_count + 1;
            if (rd_idx < stream.len()) begin
                ch     <= stream[rd_idx];
                rd_idx <= rd_idx + 1;
            end else begin
                src_done <= 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (resetn && tok_valid && tok_ready) begin
            mon_obs = {tok_type, tok_name, tok_attr, tok_value, tok_overflow};
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_token observed=%h expected=none", mon_obs);
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                checks++;
                assert (mon_obs === mon_exp) else begin
                    failures++;
                    $error("FAIL token observed=%h expected=%h", mon_obs, mon_exp);
                end
            end
        end
    end

    function automatic tok_t tk(input logic [2:0] t, input string n, input logic [1:0] a,
                                input logic [7:0] v, input logic o);
        logic [31:0] nm = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < n.len()) nm[31-8*i -: 8] = n[i];
        end
        return {t, nm, a, v, o};
    endfunction

    task automatic exp(input logic [2:0] t, input string n, input logic [1:0] a,
                       input logic [7:0] v, input logic o);
        sb.push_back(tk(t, n, a, v, o));
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_char_req"}, 64'(char_req), 64'd0);
        check({tag, "_tok_valid"}, 64'(tok_valid), 64'd0);
        check({tag, "_tok_type"}, 64'(tok_type), 64'd0);
        check({tag, "_tok_name"}, 64'(tok_name), 64'd0);
        check({tag, "_tok_attr"}, 64'(tok_attr), 64'd0);
        check({tag, "_tok_value"}, 64'(tok_value), 64'd0);
        check({tag, "_tok_overflow"}, 64'(tok_overflow), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_parse_done"}, 64'(parse_done), 64'd0);
    endtask

    task automatic start_stream(input string s);
        resetn = 1'b0;
        load   = 1'b1;
        stream = s;
        repeat (2) @(posedge clock);
        #1;
        load   = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int n = 0;
        while (!(parse_done && !tok_valid && sb.size() == 0) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        #1;
        checks++;
        assert (n < 3000) else begin
            failures++;
            $error("FAIL %s_timeout observed=%0d cycles expected=<3000 pending=%0d", tag, n, sb.size());
        end
        sb.delete();
        check({tag, "_err"}, 64'(err), 64'(exp_err));
    endtask

    task automatic exp_main();
        exp(T_OPEN, "body", 2'd0, 8'd0, 1'b0);
        exp(T_END, "", 2'd0, 8'd0, 1'b0);
        exp(T_OPEN, "p", 2'd0, 8'd0, 1'b0);
`ifdef HTML_TOKENIZER_ATTR_EN
        exp(T_ATTR, "", 2'd1, 8'd7, 1'b0);
        exp(T_ATTR, "", 2'd2, 8'd2, 1'b0);
`endif
        exp(T_END, "", 2'd0, 8'd0, 1'b0);
        exp(T_TEXT, "t", 2'd0, 8'd0, 1'b0);
        exp(T_TEXT, "e", 2'd0, 8'd0, 1'b0);
        exp(T_TEXT, "s", 2'd0, 8'd0, 1'b0);
        exp(T_TEXT, "t", 2'd0, 8'd0, 1'b0);
        exp(T_CLOSE, "p", 2'd0, 8'd0, 1'b0);
        exp(T_CLOSE, "body", 2'd0, 8'd0, 1'b0);
        exp(T_EOF, "", 2'd0, 8'd0, 1'b0);
    endtask

    initial begin
        int r0;
        int n;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");

        // Main stream, always ready
        tok_ready = 1'b1;
        exp_main();
        start_stream(MAIN);
        wait_done("main", 1'b0);
        r0 = req_count;
        repeat (20) @(posedge clock);
        #1;
        check("no_req_after_eof", 64'(req_count), 64'(r0));
        check("parse_done_final", 64'(parse_done), 64'd1);

        // Back-pressure: two tokens held, no fetch until both slots free
        tok_ready = 1'b0;
        exp_main();
        start_stream(MAIN);
        n = 0;
        while (!tok_valid && n < 500) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("bp_first_token_seen", 64'(n < 500), 64'd1);
        r0 = req_count;
        repeat (50) @(posedge clock);
        #1;
        check("bp_no_req_full", 64'(req_count), 64'(r0));
        check("bp_head_type", 64'(tok_type), 64'(T_OPEN));
        tok_ready = 1'b1;
        @(posedge clock);
        #1;
        tok_ready = 1'b0;
        r0 = req_count;
        repeat (10) @(posedge clock);
        #1;
        check("bp_no_req_one_free", 64'(req_count), 64'(r0));
        check("bp_second_head", 64'(tok_type), 64'(T_END));
        tok_ready = 1'b1;
        wait_done("backpressure", 1'b0);

        // Value saturation
        exp(T_OPEN, "p", 2'd0, 8'd0, 1'b0);
`ifdef HTML_TOKENIZER_ATTR_EN
        exp(T_ATTR, "", 2'd2, 8'd255, 1'b0);
`endif
        exp(T_END, "", 2'd0, 8'd0, 1'b0);
        exp(T_EOF, "", 2'd0, 8'd0, 1'b0);
        start_stream("<p size=300>");
        wait_done("saturate", 1'b0);

        // Bad character inside a value
        exp(T_OPEN, "p", 2'd0, 8'd0, 1'b0);
`ifdef HTML_TOKENIZER_ATTR_EN
        exp(T_ATTR, "", 2'd2, 8'd4, 1'b0);
`endif
        exp(T_END, "", 2'd0, 8'd0, 1'b0);
        exp(T_EOF, "", 2'd0, 8'd0, 1'b0);
        start_stream("<p size=4x>");
`ifdef HTML_TOKENIZER_ATTR_EN
        wait_done("bad_value", 1'b1);
`else
        wait_done("bad_value", 1'b0);
`endif

        // Name truncation, then a short name with overflow cleared
        exp(T_OPEN, "tabl", 2'd0, 8'd0, 1'b1);
        exp(T_END, "", 2'd0, 8'd0, 1'b0);
        exp(T_OPEN, "br", 2'd0, 8'd0, 1'b0);
        exp(T_END, "", 2'd0, 8'd0, 1'b0);
        exp(T_EOF, "", 2'd0, 8'd0, 1'b0);
        start_stream("<table><br>");
        wait_done("overflow", 1'b0);

        // Single attribute tag
        exp(T_OPEN, "p", 2'd0, 8'd0, 1'b0);
`ifdef HTML_TOKENIZER_ATTR_EN
        exp(T_ATTR, "", 2'd1, 8'd7, 1'b0);
`endif
        exp(T_END, "", 2'd0, 8'd0, 1'b0);
        exp(T_EOF, "", 2'd0, 8'd0, 1'b0);
        start_stream("<p color=7>");
        wait_done("color_only", 1'b0);

        // Empty open and close names
        exp(T_TEXT, "a", 2'd0, 8'd0, 1'b0);
        exp(T_EOF, "", 2'd0, 8'd0, 1'b0);
        start_stream("<>a</>");
        wait_done("empty_name", 1'b1);

        // Reset in the middle of an attribute name; reader keeps its position
        exp(T_OPEN, "p", 2'd0, 8'd0, 1'b0);
        start_stream("<p color=7>ab");
        r0 = req_count;
        n = 0;
        while (req_count < r0 + 6 && n < 500) begin
            @(posedge clock);
            n++;
        end
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        exp(T_TEXT, "o", 2'd0, 8'd0, 1'b0);
        exp(T_TEXT, "r", 2'd0, 8'd0, 1'b0);
        exp(T_TEXT, "=", 2'd0, 8'd0, 1'b0);
        exp(T_TEXT, "7", 2'd0, 8'd0, 1'b0);
        exp(T_TEXT, ">", 2'd0, 8'd0, 1'b0);
        exp(T_TEXT, "a", 2'd0, 8'd0, 1'b0);
        exp(T_TEXT, "b", 2'd0, 8'd0, 1'b0);
        exp(T_EOF, "", 2'd0, 8'd0, 1'b0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        wait_done("resume", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
